// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the ibus (fetch) and dbus (memory stage).
// dbus has priority, bounded by STARVE_LIMIT back-to-back grants while ibus waits.
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [31:0] i_data,
   input  logic        d_valid,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [63:0] d_rdata,
   output logic        m_valid,
   output logic [63:0] m_addr,
   output logic [2:0]  m_size,
   output logic [7:0]  m_strobe,
   output logic [63:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [63:0] m_rdata,
   output logic [1:0]  grant
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, ADDR_I, DATA_I, ADDR_D, DATA_D} state_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] wdata;
   } mreq_t;

   state_t        state, state_nxt;
   logic [SW-1:0] d_streak;
   logic          i_word_hi;
   logic          pick_d, pick_i;
   mreq_t         mreq;

   // ibus is forced only once dbus has used up its streak while fetch waited
   always_comb begin
      pick_d = d_valid && !(i_valid && (d_streak == SW'(STARVE_LIMIT)));
      pick_i = !pick_d && i_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_d) state_nxt = ADDR_D;
                  else if (pick_i) state_nxt = ADDR_I;
         ADDR_I:  if (m_addr_ok) state_nxt = m_data_ok ? IDLE : DATA_I;
         DATA_I:  if (m_data_ok) state_nxt = IDLE;
         ADDR_D:  if (m_addr_ok) state_nxt = m_data_ok ? IDLE : DATA_D;
         DATA_D:  if (m_data_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant     = 2'b00;
      m_valid   = 1'b0;
      i_addr_ok = 1'b0;
      i_data_ok = 1'b0;
      d_addr_ok = 1'b0;
      d_data_ok = 1'b0;
      case (state)
         ADDR_I: begin
            grant     = 2'b01;
            m_valid   = 1'b1;
            i_addr_ok = m_addr_ok;
            i_data_ok = m_addr_ok && m_data_ok;
         end
         DATA_I: begin
            grant     = 2'b01;
            i_data_ok = m_data_ok;
         end
         ADDR_D: begin
            grant     = 2'b10;
            m_valid   = 1'b1;
            d_addr_ok = m_addr_ok;
            d_data_ok = m_addr_ok && m_data_ok;
         end
         DATA_D: begin
            grant     = 2'b10;
            d_data_ok = m_data_ok;
         end
         default: ;
      endcase
   end

   always_comb begin
      i_data  = i_data_ok ? (i_word_hi ? m_rdata[63:32] : m_rdata[31:0]) : 32'd0;
      d_rdata = d_data_ok ? m_rdata : 64'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mreq      <= '0;
         i_word_hi <= 1'b0;
         d_streak  <= '0;
      end else if (state == IDLE) begin
         if (pick_d) begin
            mreq <= '{addr: d_addr, size: d_size, strobe: d_strobe, wdata: d_wdata};
            if (!i_valid)
               d_streak <= '0;
            else if (d_streak != SW'(STARVE_LIMIT))
               d_streak <= d_streak + 1'b1;
         end else if (pick_i) begin
            mreq      <= '{addr: i_addr, size: 3'b010, strobe: 8'd0, wdata: 64'd0};
            i_word_hi <= i_addr[2];
            d_streak  <= '0;
         end
      end
   end

   assign m_addr   = mreq.addr;
   assign m_size   = mreq.size;
   assign m_strobe = mreq.strobe;
   assign m_wdata  = mreq.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a transaction-level
// model that tracks only who owns the port and whether its address was taken.
module tb_mem_bus_arbiter;
   localparam int LIM = 4;

   logic        clk, reset;
   logic        i_valid, i_addr_ok, i_data_ok;
   logic [63:0] i_addr;
   logic [31:0] i_data;
   logic        d_valid, d_addr_ok, d_data_ok;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic        m_valid, m_addr_ok, m_data_ok;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [1:0]  grant;

   mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
      .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, passed = 0, failed = 0;

   // reference model: owner 0 none / 1 ibus / 2 dbus, plus "address accepted"
   int          own, streak;
   bit          acc;
   logic [63:0] l_addr, l_wdata;
   logic [2:0]  l_size;
   logic [7:0]  l_strb;
   bit          l_hi;

   bit i_busy, d_busy, i_done, d_done;
   int req_mode;  // 0 directed, 1 random, 2 both requesters always asking

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_grant"}, 64'(grant), 64'd0);
      chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
      chk({tag, "_mfields"}, m_addr | m_wdata | 64'(m_size) | 64'(m_strobe), 64'd0);
      chk({tag, "_acks"}, 64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'd0);
   endtask

   task automatic drive_req();
      if (i_done) begin i_valid = 1'b0; i_busy = 1'b0; end
      if (d_done) begin d_valid = 1'b0; d_busy = 1'b0; end
      if (req_mode == 0) return;
      if (!i_busy && (req_mode == 2 || $urandom_range(0, 2) == 0)) begin
         i_valid = 1'b1; i_busy = 1'b1;
         i_addr  = {$urandom, $urandom} & ~64'h3;
      end
      // a dbus requester that gives up after its address was taken
      if (req_mode == 1 && own == 2 && acc && d_valid && $urandom_range(0, 5) == 0)
         d_valid = 1'b0;
      if (!d_busy && (req_mode == 2 || $urandom_range(0, 2) == 0)) begin
         d_valid  = 1'b1; d_busy = 1'b1;
         d_addr   = {$urandom, $urandom};
         d_size   = 3'($urandom_range(0, 3));
         d_strobe = 8'($urandom);
         d_wdata  = {$urandom, $urandom};
      end
   endtask

   // ao/dk: 0 or 1 forces m_addr_ok/m_data_ok, 2 randomizes
   task automatic cycle(input int ao, input int dk);
      logic e_mv, e_iao, e_ido, e_dao, e_ddo;
      logic [31:0] e_idata;
      logic [63:0] e_drd;
      drive_req();
      m_addr_ok = (ao == 2) ? ($urandom_range(0, 3) != 0) : (ao != 0);
      m_data_ok = (dk == 2) ? ($urandom_range(0, 2) == 0) : (dk != 0);
      m_rdata   = {$urandom, $urandom};
      #2;
      e_mv    = (own != 0) && !acc;
      e_iao   = (own == 1) && !acc && m_addr_ok;
      e_ido   = (own == 1) && (acc || m_addr_ok) && m_data_ok;
      e_dao   = (own == 2) && !acc && m_addr_ok;
      e_ddo   = (own == 2) && (acc || m_addr_ok) && m_data_ok;
      e_idata = !e_ido ? 32'd0 : (l_hi ? m_rdata[63:32] : m_rdata[31:0]);
      e_drd   = e_ddo ? m_rdata : 64'd0;
      chk("grant", 64'(grant), 64'(own));
      chk("m_valid", 64'(m_valid), 64'(e_mv));
      chk("i_addr_ok", 64'(i_addr_ok), 64'(e_iao));
      chk("i_data_ok", 64'(i_data_ok), 64'(e_ido));
      chk("d_addr_ok", 64'(d_addr_ok), 64'(e_dao));
      chk("d_data_ok", 64'(d_data_ok), 64'(e_ddo));
      chk("i_data", 64'(i_data), 64'(e_idata));
      chk("d_rdata", d_rdata, e_drd);
      if (e_mv) begin
         chk("m_addr", m_addr, l_addr);
         chk("m_size", 64'(m_size), 64'(l_size));
         chk("m_strobe", 64'(m_strobe), 64'(l_strb));
         chk("m_wdata", m_wdata, l_wdata);
      end
      i_done = e_ido;
      d_done = e_ddo;
      if (own == 0) begin
         acc = 1'b0;
         if (d_valid && !(i_valid && streak == LIM)) begin
            own = 2;
            l_addr = d_addr; l_size = d_size; l_strb = d_strobe; l_wdata = d_wdata;
            streak = i_valid ? ((streak < LIM) ? streak + 1 : LIM) : 0;
         end else if (i_valid) begin
            own = 1;
            l_addr = i_addr; l_size = 3'b010; l_strb = 8'd0; l_wdata = 64'd0;
            l_hi = i_addr[2];
            streak = 0;
         end
      end else if (e_ido || e_ddo) begin
         own = 0;
      end else if (e_iao || e_dao) begin
         acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      i_valid = 1'b0; d_valid = 1'b0;
      i_busy = 1'b0; d_busy = 1'b0; i_done = 1'b0; d_done = 1'b0;
      own = 0; acc = 1'b0; streak = 0;
   endtask

   initial begin
      bit found;
      reset = 1'b0;
      i_addr = '0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
      m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = '1;
      l_addr = '0; l_size = '0; l_strb = '0; l_wdata = '0; l_hi = 1'b0;
      req_mode = 0;
      model_reset();
      #3;
      chk_quiet("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // single fetch from an upper-word address with a two-cycle data wait
      i_valid = 1'b1; i_busy = 1'b1; i_addr = 64'h8000_0004;
      cycle(0, 0); cycle(1, 0); cycle(0, 0); cycle(0, 1); cycle(0, 0);

      // simultaneous requests: dbus first, then ibus
      i_valid = 1'b1; i_busy = 1'b1; i_addr = 64'h0000_1000;
      d_valid = 1'b1; d_busy = 1'b1; d_addr = 64'h0000_2008;
      d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'd0;
      for (int k = 0; k < 60 && (i_busy || d_busy); k++) cycle(2, 2);
      chk("simul_done", 64'(i_busy || d_busy), 64'd0);

      // dbus write with same-cycle address and data acceptance
      d_valid = 1'b1; d_busy = 1'b1; d_addr = 64'h100;
      d_size = 3'd2; d_strobe = 8'h0F; d_wdata = 64'hDEAD_BEEF;
      cycle(1, 1); cycle(1, 1); cycle(1, 1);

      // spurious memory acks while idle, then address ack during DATA_I
      cycle(1, 1); cycle(1, 1);
      i_valid = 1'b1; i_busy = 1'b1; i_addr = 64'h40;
      cycle(1, 0); cycle(1, 0); cycle(1, 0); cycle(1, 0); cycle(0, 1); cycle(0, 0);

      // both requesters always asking, zero-wait memory: starvation bound
      req_mode = 2;
      for (int k = 0; k < 60; k++) cycle(1, 1);

      req_mode = 1;
      for (int k = 0; k < 1500; k++) cycle(2, 2);

      // reset while dbus owns the port with its address still outstanding
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         if (own == 2 && !acc) found = 1'b1;
         else cycle(2, 0);
      end
      chk("reach_addr_d", 64'(found), 64'd1);
      reset = 1'b0;
      model_reset();
      #1;
      chk_quiet("midreset");
      @(posedge clk); #1;
      chk_quiet("midreset_hold");
      reset = 1'b1;

      for (int k = 0; k < 300; k++) cycle(2, 2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
